gpio_cmd_ctrl: RTL and testbench

//  Command/response bridge between the MicroBlaze 32-bit GPIO pair and the 2D-convolution core.
//  It decodes host words on gpio_o_data_tri_o using a toggle-bit request/acknowledge handshake.

---
 rtl/gpio_cmd_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_gpio_cmd_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/gpio_cmd_ctrl.sv
// Decodes toggle-handshake GPIO command words into kernel loads, pixel writes, conv start and result reads.
// Ack appears three cycles after a request for simple ops; requests arriving while busy are dropped and flagged in the sticky error bit.
module gpio_cmd_ctrl #(
  parameter int GPIO_D     = 32,
  parameter int BIT_LEN    = 8,
  parameter int M_LEN      = 3,
  parameter int NB_ADDRESS = 10,
  parameter int RAM_WIDTH  = 13,
  parameter int RD_LAT     = 2,
  parameter int TIMEOUT    = 2**20
) (
  input  logic                             CLK100MHZ,
  input  logic                             ck_rst,
  input  logic [GPIO_D-1:0]                i_gpio_cmd,
  output logic [GPIO_D-1:0]                o_gpio_rsp,
  output logic [M_LEN*M_LEN*BIT_LEN-1:0]   o_kernel,
  output logic                             o_ram_we,
  output logic [NB_ADDRESS-1:0]            o_ram_addr,
  output logic [BIT_LEN-1:0]               o_ram_data,
  output logic                             o_start,
  input  logic                             i_done,
  output logic [NB_ADDRESS-1:0]            o_rd_addr,
  input  logic [RAM_WIDTH-1:0]             i_rd_data,
  output logic                             o_busy
);

  localparam int NCOEF = M_LEN * M_LEN;
  localparam int KW    = NCOEF * BIT_LEN;
  localparam int CMAX  = (TIMEOUT > RD_LAT) ? TIMEOUT : RD_LAT;
  localparam int CW    = $clog2(CMAX + 1);

  localparam logic [2:0] OP_NOP    = 3'd0;
  localparam logic [2:0] OP_KERNEL = 3'd1;
  localparam logic [2:0] OP_PIXEL  = 3'd2;
  localparam logic [2:0] OP_START  = 3'd3;
  localparam logic [2:0] OP_READ   = 3'd4;
  localparam logic [2:0] OP_STATUS = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_WAIT_DONE,
    S_RD_WAIT,
    S_ACK
  } state_t;

  state_t                 state_q, state_d;
  logic                   req_last_q, req_last_d;
  logic [2:0]             op_q, op_d;
  logic                   tog_q, tog_d;
  logic [3:0]             idx_q, idx_d;
  logic [NB_ADDRESS-1:0]  addr_q, addr_d;
  logic [BIT_LEN-1:0]     data_q, data_d;
  logic                   busy_acc_q, busy_acc_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   err_q, err_d;
  logic                   ack_q, ack_d;
  logic                   busy_q, busy_d;
  logic [RAM_WIDTH-1:0]   rsp_data_q, rsp_data_d;
  logic [KW-1:0]          kernel_q, kernel_d;
  logic                   ram_we_q, ram_we_d;
  logic [NB_ADDRESS-1:0]  ram_addr_q, ram_addr_d;
  logic [BIT_LEN-1:0]     ram_data_q, ram_data_d;
  logic                   start_q, start_d;
  logic [NB_ADDRESS-1:0]  rd_addr_q, rd_addr_d;

  logic req_edge;
  logic err_set;
  logic err_clr;
  logic unused_cmd;

  assign unused_cmd = ^i_gpio_cmd[23:NB_ADDRESS+8];
  assign req_edge   = i_gpio_cmd[28] ^ req_last_q;

  always_comb begin
    state_d    = state_q;
    req_last_d = req_last_q;
    op_d       = op_q;
    tog_d      = tog_q;
    idx_d      = idx_q;
    addr_d     = addr_q;
    data_d     = data_q;
    busy_acc_d = busy_acc_q;
    cnt_d      = cnt_q;
    ack_d      = ack_q;
    busy_d     = (state_q != S_IDLE);
    rsp_data_d = rsp_data_q;
    kernel_d   = kernel_q;
    ram_we_d   = 1'b0;
    ram_addr_d = ram_addr_q;
    ram_data_d = ram_data_q;
    start_d    = 1'b0;
    rd_addr_d  = rd_addr_q;
    err_set    = 1'b0;
    err_clr    = 1'b0;

    case (state_q)
      S_EXEC: begin
        cnt_d   = '0;
        state_d = S_ACK;
        case (op_q)
          OP_NOP: ;
          OP_KERNEL: begin
            if (int'(idx_q) < NCOEF) kernel_d[int'(idx_q)*BIT_LEN +: BIT_LEN] = data_q;
            else                     err_set = 1'b1;
          end
          OP_PIXEL: begin
            ram_we_d   = 1'b1;
            ram_addr_d = addr_q;
            ram_data_d = data_q;
          end
          OP_START: begin
            start_d = 1'b1;
            state_d = S_WAIT_DONE;
          end
          OP_READ: begin
            rd_addr_d = addr_q;
            state_d   = S_RD_WAIT;
          end
          OP_STATUS: begin
            rsp_data_d = RAM_WIDTH'({err_q, busy_acc_q});
            err_clr    = 1'b1;
          end
          default: err_set = 1'b1;
        endcase
      end
      S_WAIT_DONE: begin
        // A done level still asserted from a previous run is ignored while start is out.
        if (i_done && !start_q) begin
          state_d = S_ACK;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          err_set = 1'b1;
          state_d = S_ACK;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RD_WAIT: begin
        if (cnt_q == CW'(RD_LAT - 1)) begin
          rsp_data_d = i_rd_data;
          state_d    = S_ACK;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_ACK: begin
        ack_d   = tog_q;
        state_d = S_IDLE;
      end
      default: ;
    endcase

    if (req_edge) begin
      req_last_d = i_gpio_cmd[28];
      if (state_q == S_IDLE) begin
        op_d       = i_gpio_cmd[31:29];
        tog_d      = i_gpio_cmd[28];
        idx_d      = i_gpio_cmd[27:24];
        addr_d     = i_gpio_cmd[NB_ADDRESS+7:8];
        data_d     = i_gpio_cmd[BIT_LEN-1:0];
        busy_acc_d = busy_q;
        state_d    = S_EXEC;
      end else begin
        err_set = 1'b1;
      end
    end

    // A fresh error in the STATUS cycle must survive the read-clear.
    err_d = (err_clr ? 1'b0 : err_q) | err_set;
  end

  always_ff @(posedge CLK100MHZ) begin
    if (!ck_rst) begin
      state_q    <= S_IDLE;
      req_last_q <= i_gpio_cmd[28];
      op_q       <= '0;
      tog_q      <= 1'b0;
      idx_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      busy_acc_q <= 1'b0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      ack_q      <= i_gpio_cmd[28];
      busy_q     <= 1'b0;
      rsp_data_q <= '0;
      kernel_q   <= '0;
      ram_we_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_data_q <= '0;
      start_q    <= 1'b0;
      rd_addr_q  <= '0;
    end else begin
      state_q    <= state_d;
      req_last_q <= req_last_d;
      op_q       <= op_d;
      tog_q      <= tog_d;
      idx_q      <= idx_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      busy_acc_q <= busy_acc_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
      rsp_data_q <= rsp_data_d;
      kernel_q   <= kernel_d;
      ram_we_q   <= ram_we_d;
      ram_addr_q <= ram_addr_d;
      ram_data_q <= ram_data_d;
      start_q    <= start_d;
      rd_addr_q  <= rd_addr_d;
    end
  end

  assign o_gpio_rsp = {ack_q, busy_q, err_q, {(GPIO_D-3-RAM_WIDTH){1'b0}}, rsp_data_q};
  assign o_kernel   = kernel_q;
  assign o_ram_we   = ram_we_q;
  assign o_ram_addr = ram_addr_q;
  assign o_ram_data = ram_data_q;
  assign o_start    = start_q;
  assign o_rd_addr  = rd_addr_q;
  assign o_busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_gpio_cmd_ctrl.sv
// Bench for gpio_cmd_ctrl: table of host commands plus hand-written START/reset/overlap sequences.
module tb_gpio_cmd_ctrl;

  logic        clk = 1'b0;
  logic        ck_rst;
  logic [31:0] i_gpio_cmd;
  logic [31:0] o_gpio_rsp;
  logic [71:0] o_kernel;
  logic        o_ram_we;
  logic [9:0]  o_ram_addr;
  logic [7:0]  o_ram_data;
  logic        o_start;
  logic        i_done;
  logic [9:0]  o_rd_addr;
  logic [12:0] i_rd_data;
  logic        o_busy;

  always #5 clk = ~clk;

  // Result RAM stand-in: address 5 holds 0x1ABC, every other address reads back as itself.
  assign i_rd_data = (o_rd_addr == 10'd5) ? 13'h1ABC : {3'b0, o_rd_addr};

  gpio_cmd_ctrl #(.TIMEOUT(64), .RD_LAT(2)) dut (
    .CLK100MHZ  (clk),
    .ck_rst     (ck_rst),
    .i_gpio_cmd (i_gpio_cmd),
    .o_gpio_rsp (o_gpio_rsp),
    .o_kernel   (o_kernel),
    .o_ram_we   (o_ram_we),
    .o_ram_addr (o_ram_addr),
    .o_ram_data (o_ram_data),
    .o_start    (o_start),
    .i_done     (i_done),
    .o_rd_addr  (o_rd_addr),
    .i_rd_data  (i_rd_data),
    .o_busy     (o_busy)
  );

  int n_vec = 0;
  int n_err = 0;
  int we_cnt = 0;
  int start_cnt = 0;
  logic [9:0] we_addr = '0;
  logic [7:0] we_data = '0;

  always @(posedge clk) begin
    if (o_ram_we) begin
      we_cnt  <= we_cnt + 1;
      we_addr <= o_ram_addr;
      we_data <= o_ram_data;
    end
    if (o_start) start_cnt <= start_cnt + 1;
  end

  logic        tog;
  logic        merr;
  logic [12:0] mdata;
  logic [71:0] mkern;
  bit          exp_timeout;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [2:0] op;
    logic [3:0] idx;
    logic [9:0] addr;
    logic [7:0] data;
    int         lat;
  } vec_t;
  vec_t vt[20];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input string name, input logic [2:0] op, input logic [3:0] idx,
                      input logic [9:0] addr, input logic [7:0] data, input int max_cyc,
                      output int lat);
    logic [31:0] e;
    case (op)
      3'd1: if (idx < 4'd9) mkern[idx*8 +: 8] = data; else merr = 1'b1;
      3'd3: if (exp_timeout) merr = 1'b1;
      3'd4: mdata = (addr == 10'd5) ? 13'h1ABC : {3'b0, addr};
      3'd5: begin mdata = {11'b0, merr, 1'b0}; merr = 1'b0; end
      3'd6, 3'd7: merr = 1'b1;
      default: ;
    endcase
    tog = ~tog;
    exp_q.push_back({tog, 1'b0, merr, 16'b0, mdata});
    @(negedge clk);
    i_gpio_cmd = {op, tog, idx, 6'b0, addr, data};
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (o_gpio_rsp[31] !== tog && lat < max_cyc);
    e = exp_q.pop_front();
    chk(name, o_gpio_rsp & 32'hBFFF_FFFF, e);
  endtask

  initial begin
    int lat;
    int s0;
    logic t_read;

    ck_rst = 1'b0; i_gpio_cmd = 32'h1000_0000; i_done = 1'b0;
    tog = 1'b1; merr = 1'b0; mdata = '0; mkern = '0; exp_timeout = 1'b0;
    repeat (3) @(negedge clk);
    ck_rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_rsp", o_gpio_rsp, 32'h8000_0000);
    chk("reset_busy", o_busy, 1'b0);
    chk("reset_kernel", o_kernel, 72'h0);
    chk("reset_pulses", we_cnt + start_cnt, 0);

    for (int k = 0; k < 9; k++) begin
      vt[k].op = 3'd1; vt[k].idx = 4'(k); vt[k].addr = '0; vt[k].data = 8'(8'h11 * k); vt[k].lat = 3;
    end
    vt[9]  = '{3'd2, 4'd0, 10'h3FF, 8'hA5, 3};
    vt[10] = '{3'd0, 4'd0, 10'h000, 8'h00, 3};
    vt[11] = '{3'd1, 4'd9, 10'h000, 8'hFF, 3};
    vt[12] = '{3'd5, 4'd0, 10'h000, 8'h00, 3};
    vt[13] = '{3'd5, 4'd0, 10'h000, 8'h00, 3};
    vt[14] = '{3'd6, 4'd0, 10'h000, 8'h00, 3};
    vt[15] = '{3'd7, 4'd0, 10'h000, 8'h00, 3};
    vt[16] = '{3'd5, 4'd0, 10'h000, 8'h00, 3};
    vt[17] = '{3'd4, 4'd0, 10'h005, 8'h00, 5};
    vt[18] = '{3'd0, 4'd0, 10'h000, 8'h00, 3};
    vt[19] = '{3'd4, 4'd0, 10'h007, 8'h00, 5};

    for (int i = 0; i < 20; i++) begin
      send($sformatf("vec%0d_rsp", i), vt[i].op, vt[i].idx, vt[i].addr, vt[i].data, 20, lat);
      chk($sformatf("vec%0d_lat", i), lat, vt[i].lat);
    end
    chk("kernel_bank", o_kernel, mkern);
    chk("pixel_we_count", we_cnt, 1);
    chk("pixel_addr", we_addr, 10'h3FF);
    chk("pixel_data", we_data, 8'hA5);
    chk("pixel_hold", {o_ram_addr, o_ram_data}, {10'h3FF, 8'hA5});

    // START with done arriving 50 cycles after the request.
    s0 = start_cnt;
    fork
      send("start_done_rsp", 3'd3, 4'd0, 10'd0, 8'd0, 200, lat);
      begin
        repeat (26) @(negedge clk);
        chk("start_busy_wait", {o_busy, o_gpio_rsp[30]}, 2'b11);
        repeat (25) @(negedge clk);
        i_done = 1'b1;
      end
    join
    i_done = 1'b0;
    chk("start_done_lat", lat, 52);
    chk("start_pulse_once", start_cnt - s0, 1);

    // done already high during the start pulse must not complete the wait.
    i_done = 1'b1;
    send("start_stale_done_rsp", 3'd3, 4'd0, 10'd0, 8'd0, 20, lat);
    i_done = 1'b0;
    chk("start_stale_done_lat", lat, 5);

    exp_timeout = 1'b1;
    send("start_timeout_rsp", 3'd3, 4'd0, 10'd0, 8'd0, 200, lat);
    exp_timeout = 1'b0;
    chk("start_timeout_lat", lat, 67);
    send("status_after_timeout", 3'd5, 4'd0, 10'd0, 8'd0, 20, lat);
    send("status_cleared", 3'd5, 4'd0, 10'd0, 8'd0, 20, lat);

    // Reset in the middle of a START wait aborts it cleanly.
    send("err_before_reset", 3'd6, 4'd0, 10'd0, 8'd0, 20, lat);
    tog = ~tog;
    @(negedge clk);
    i_gpio_cmd = {3'd3, tog, 4'd0, 6'b0, 10'd0, 8'd0};
    repeat (10) @(negedge clk);
    ck_rst = 1'b0;
    @(negedge clk);
    ck_rst = 1'b1;
    s0 = start_cnt;
    merr = 1'b0; mdata = '0; mkern = '0;
    repeat (5) @(negedge clk);
    chk("midreset_busy", o_busy, 1'b0);
    chk("midreset_rsp", o_gpio_rsp, {tog, 31'b0});
    chk("midreset_kernel", o_kernel, 72'h0);
    chk("midreset_no_start", start_cnt, s0);
    send("post_reset_load", 3'd1, 4'd2, 10'd0, 8'h5A, 20, lat);
    chk("post_reset_kernel", o_kernel, mkern);

    // A second toggle while the READ is in flight is dropped and flagged.
    tog = ~tog;
    t_read = tog;
    @(negedge clk);
    i_gpio_cmd = {3'd4, tog, 4'd0, 6'b0, 10'd5, 8'd0};
    @(negedge clk);
    tog = ~tog;
    i_gpio_cmd = {3'd0, tog, 4'd0, 6'b0, 10'd0, 8'd0};
    lat = 0;
    while (o_gpio_rsp[31] !== t_read && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("overlap_rsp", o_gpio_rsp & 32'hBFFF_FFFF, {t_read, 1'b0, 1'b1, 16'b0, 13'h1ABC});
    repeat (5) @(negedge clk);
    chk("overlap_dropped", {o_busy, o_gpio_rsp[31]}, {1'b0, t_read});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
